// File: rtl/ntm_read_head_stream.sv
// Streaming NTM read head: r(j) = sum_i w(i)*M(i,j), with w loaded first and
// M streamed column-major. One fixed-point r(j) word is emitted per completed column.
module ntm_read_head_stream #(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int N             = 64,
  parameter int W             = 64,
  parameter int FRACTION_SIZE = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    READY,
  input  logic                    W_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    W_IN,
  input  logic                    M_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    M_IN,
  output logic                    R_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    R_OUT,
  output logic [CONTROL_SIZE-1:0] R_INDEX
);

  // state  | meaning
  // IDLE   | waiting for START
  // LOAD_W | capturing w(0..N-1)
  // LOAD_M | accumulating columns of M, emitting r(j) per column
  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_M} state_t;

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int JW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N - 1);
  localparam logic [JW-1:0] J_LAST = JW'(W - 1);

  state_t                  state_q, state_d;
  logic [IW-1:0]           i_q, i_d;
  logic [JW-1:0]           j_q, j_d;
  logic [DATA_SIZE-1:0]    acc_q, acc_d;
  logic [DATA_SIZE-1:0]    w_q [N];
  logic [DATA_SIZE-1:0]    w_d [N];
  logic                    ready_q, ready_d;
  logic                    r_en_q, r_en_d;
  logic [DATA_SIZE-1:0]    r_out_q, r_out_d;
  logic [CONTROL_SIZE-1:0] r_idx_q, r_idx_d;

  logic [DATA_SIZE-1:0]           w_cur;
  logic signed [2*DATA_SIZE-1:0]  w_ext, m_ext, prod;
  logic [DATA_SIZE-1:0]           term;

  // Full-width signed product, arithmetic shift back to the fixed-point grid, then wrap.
  assign w_cur = w_q[i_q];
  assign w_ext = {{DATA_SIZE{w_cur[DATA_SIZE-1]}}, w_cur};
  assign m_ext = {{DATA_SIZE{M_IN[DATA_SIZE-1]}}, M_IN};
  assign prod  = w_ext * m_ext;
  assign term  = DATA_SIZE'(prod >>> FRACTION_SIZE);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    w_d     = w_q;
    ready_d = 1'b0;
    r_en_d  = 1'b0;
    r_out_d = r_out_q;
    r_idx_d = r_idx_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = LOAD_W;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
        end
      end
      LOAD_W: begin
        if (W_IN_ENABLE) begin
          w_d[i_q] = W_IN;
          if (i_q == I_LAST) begin
            state_d = LOAD_M;
            i_d     = '0;
            j_d     = '0;
            acc_d   = '0;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      LOAD_M: begin
        if (M_IN_ENABLE) begin
          if (i_q == I_LAST) begin
            r_out_d = acc_q + term;
            r_idx_d = CONTROL_SIZE'(j_q);
            r_en_d  = 1'b1;
            acc_d   = '0;
            i_d     = '0;
            if (j_q == J_LAST) begin
              ready_d = 1'b1;
              state_d = IDLE;
              j_d     = '0;
            end else begin
              j_d = j_q + 1'b1;
            end
          end else begin
            acc_d = acc_q + term;
            i_d   = i_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      ready_q <= 1'b0;
      r_en_q  <= 1'b0;
      r_out_q <= '0;
      r_idx_q <= '0;
      for (int k = 0; k < N; k++) w_q[k] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      ready_q <= ready_d;
      r_en_q  <= r_en_d;
      r_out_q <= r_out_d;
      r_idx_q <= r_idx_d;
      w_q     <= w_d;
    end
  end

  assign BUSY         = (state_q != IDLE);
  assign READY        = ready_q;
  assign R_OUT_ENABLE = r_en_q;
  assign R_OUT        = r_out_q;
  assign R_INDEX      = r_idx_q;

endmodule

// File: tb/tb_ntm_read_head_stream.sv
// Bench for ntm_read_head_stream: table vectors, reset corner cases and random
// operations checked against a plain-arithmetic read-vector model.
module tb_ntm_read_head_stream;

  localparam int DS = 16;
  localparam int CS = 8;
  localparam int NN = 4;
  localparam int WW = 3;

  typedef struct packed {
    logic [NN-1:0][DS-1:0]    w;
    logic [NN*WW-1:0][DS-1:0] m;
    logic [WW-1:0][DS-1:0]    r;
    bit gaps;
    bit ign;
    bit frac;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, w_en, m_en;
  logic [DS-1:0] w_in, m_in;

  logic busy0, ready0, ren0, busy1, ready1, ren1;
  logic [DS-1:0] rout0, rout1;
  logic [CS-1:0] ridx0, ridx1;

  bit sel;
  logic c_busy, c_ready, c_ren;
  logic [DS-1:0] c_rout;
  logic [CS-1:0] c_ridx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ntm_read_head_stream #(.DATA_SIZE(DS), .CONTROL_SIZE(CS), .N(NN), .W(WW), .FRACTION_SIZE(0)) dut0 (
    .CLK(clk), .RST(rst), .START(start), .BUSY(busy0), .READY(ready0),
    .W_IN_ENABLE(w_en), .W_IN(w_in), .M_IN_ENABLE(m_en), .M_IN(m_in),
    .R_OUT_ENABLE(ren0), .R_OUT(rout0), .R_INDEX(ridx0));

  ntm_read_head_stream #(.DATA_SIZE(DS), .CONTROL_SIZE(CS), .N(NN), .W(WW), .FRACTION_SIZE(8)) dut1 (
    .CLK(clk), .RST(rst), .START(start), .BUSY(busy1), .READY(ready1),
    .W_IN_ENABLE(w_en), .W_IN(w_in), .M_IN_ENABLE(m_en), .M_IN(m_in),
    .R_OUT_ENABLE(ren1), .R_OUT(rout1), .R_INDEX(ridx1));

  assign c_busy  = sel ? busy1  : busy0;
  assign c_ready = sel ? ready1 : ready0;
  assign c_ren   = sel ? ren1   : ren0;
  assign c_rout  = sel ? rout1  : rout0;
  assign c_ridx  = sel ? ridx1  : ridx0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // r(j) straight from the definition: exact products, shift, sum, wrap at the end.
  function automatic logic [DS-1:0] model_r(input logic [NN-1:0][DS-1:0] w,
                                             input logic [NN*WW-1:0][DS-1:0] m,
                                             input int j, input int frac);
    longint acc = 0;
    longint p;
    for (int i = 0; i < NN; i++) begin
      p = longint'($signed(w[i])) * longint'($signed(m[j*NN+i]));
      p = p >>> frac;
      acc += p;
    end
    return acc[DS-1:0];
  endfunction

  task automatic run_op(input vec_t v);
    int ngap;
    sel   = v.frac;
    start = 1'b1;
    step();
    start = v.ign;
    chk("busy_after_start", {31'd0, c_busy}, 32'd1);
    for (int i = 0; i < NN; i++) begin
      ngap = v.gaps ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < ngap; g++) begin
        w_en = 1'b0; m_en = v.ign; m_in = DS'($urandom);
        step();
        chk("no_pulse_w_gap", {31'd0, c_ren}, 32'd0);
      end
      w_en = 1'b1; w_in = v.w[i]; m_en = v.ign; m_in = DS'($urandom);
      step();
      chk("busy_load_w", {31'd0, c_busy}, 32'd1);
      chk("no_pulse_load_w", {31'd0, c_ren}, 32'd0);
    end
    w_en = 1'b0; m_en = 1'b0;
    for (int j = 0; j < WW; j++) begin
      for (int i = 0; i < NN; i++) begin
        ngap = v.gaps ? $urandom_range(0, 2) : 0;
        for (int g = 0; g < ngap; g++) begin
          m_en = 1'b0; w_en = v.ign; w_in = DS'($urandom);
          step();
          chk("no_pulse_m_gap", {31'd0, c_ren}, 32'd0);
          if (j > 0) chk("hold_gap", {16'd0, c_rout}, {16'd0, v.r[j-1]});
        end
        m_en = 1'b1; m_in = v.m[j*NN+i]; w_en = v.ign; w_in = DS'($urandom);
        step();
        if (i == NN - 1) begin
          chk("r_en_pulse", {31'd0, c_ren}, 32'd1);
          chk("r_out", {16'd0, c_rout}, {16'd0, v.r[j]});
          chk("r_index", {24'd0, c_ridx}, j);
          chk("ready", {31'd0, c_ready}, (j == WW - 1) ? 32'd1 : 32'd0);
          chk("busy_col_end", {31'd0, c_busy}, (j == WW - 1) ? 32'd0 : 32'd1);
        end else begin
          chk("no_pulse_mid", {31'd0, c_ren}, 32'd0);
          chk("no_ready_mid", {31'd0, c_ready}, 32'd0);
          if (j > 0) chk("hold_mid", {16'd0, c_rout}, {16'd0, v.r[j-1]});
        end
      end
    end
    m_en = 1'b0; w_en = 1'b0; start = 1'b0;
  endtask

  vec_t vecs[6];
  vec_t rv;

  initial begin
    for (int k = 0; k < 6; k++) vecs[k] = '0;
    vecs[0].w[1] = 16'd1;
    for (int j = 0; j < WW; j++)
      for (int i = 0; i < NN; i++) vecs[0].m[j*NN+i] = 16'(10*j + i);
    vecs[0].r[0] = 16'd1; vecs[0].r[1] = 16'd11; vecs[0].r[2] = 16'd21;

    for (int k = 0; k < NN*WW; k++) vecs[1].m[k] = 16'd5;
    for (int i = 0; i < NN; i++) vecs[1].w[i] = 16'd1;
    for (int j = 0; j < WW; j++) vecs[1].r[j] = 16'd20;
    vecs[1].gaps = 1'b1;

    vecs[2].w[0] = 16'hFFFF;
    vecs[2].m[0] = 16'd3;
    vecs[2].r[0] = 16'hFFFD;

    for (int i = 0; i < NN; i++) vecs[3].w[i] = 16'h4000;
    for (int k = 0; k < NN*WW; k++) vecs[3].m[k] = 16'd2;

    vecs[4] = vecs[0];
    vecs[4].ign = 1'b1;

    vecs[5].w[0] = 16'h0180;
    for (int k = 0; k < NN*WW; k++) vecs[5].m[k] = 16'h0200;
    for (int j = 0; j < WW; j++) vecs[5].r[j] = 16'h0300;
    vecs[5].frac = 1'b1;

    rst = 1'b1; start = 1'b0; w_en = 1'b0; m_en = 1'b0; w_in = '0; m_in = '0; sel = 1'b0;
    step();
    step();
    chk("rst_busy", {31'd0, c_busy}, 32'd0);
    chk("rst_ready", {31'd0, c_ready}, 32'd0);
    chk("rst_ren", {31'd0, c_ren}, 32'd0);
    chk("rst_rout", {16'd0, c_rout}, 32'd0);
    chk("rst_ridx", {24'd0, c_ridx}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_busy", {31'd0, c_busy}, 32'd0);

    for (int k = 0; k < 6; k++) run_op(vecs[k]);

    // Reset in the middle of the third column.
    sel = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < NN; i++) begin
      w_en = 1'b1; w_in = vecs[0].w[i];
      step();
    end
    w_en = 1'b0;
    for (int k = 0; k < 2*NN + 2; k++) begin
      m_en = 1'b1; m_in = vecs[0].m[k];
      step();
    end
    m_en = 1'b0;
    chk("pre_rst_rout", {16'd0, c_rout}, 32'd11);
    chk("pre_rst_busy", {31'd0, c_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, c_busy}, 32'd0);
    chk("async_rst_rout", {16'd0, c_rout}, 32'd0);
    chk("async_rst_ridx", {24'd0, c_ridx}, 32'd0);
    chk("async_rst_ren", {31'd0, c_ren}, 32'd0);
    chk("async_rst_ready", {31'd0, c_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    run_op(vecs[0]);

    for (int n = 0; n < 20; n++) begin
      rv = '0;
      for (int i = 0; i < NN; i++) rv.w[i] = DS'($urandom);
      for (int k = 0; k < NN*WW; k++) rv.m[k] = DS'($urandom);
      rv.frac = 1'($urandom_range(0, 1));
      rv.ign  = 1'($urandom_range(0, 1));
      rv.gaps = 1'b1;
      for (int j = 0; j < WW; j++) rv.r[j] = model_r(rv.w, rv.m, j, rv.frac ? 8 : 0);
      run_op(rv);
    end

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ntm_read_head_stream.md
Name: ntm_read_head_stream

Overview:
- Streaming read head for the NTM memory: computes the read vector r(j) = sum over i of w(i)*M(i,j), for i in 0..N-1 and j in 0..W-1.
- Accepts the weighting vector w (N words), then the memory matrix M streamed column-major (j outer, i inner).
- Emits one r(j) word per completed column.
- Counterpart of the NTM write head: it consumes the memory matrix that the writer produces. It sits between the memory and the controller inside the accelerator top.

Parameters:
- DATA_SIZE, 64, word width of w, M and r; signed two's complement fixed point.
- CONTROL_SIZE, 64, width of the index outputs.
- N, 64, number of memory rows (weighting length).
- W, 64, number of memory columns (read vector length).
- FRACTION_SIZE, 32, fractional bits of the fixed-point format.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- START  in  1  begin an operation; sampled only in IDLE.
- BUSY  out  1  high from the cycle after START until READY.
- READY  out  1  one-cycle pulse: operation complete.
- W_IN_ENABLE  in  1  W_IN valid this cycle.
- W_IN  in  DATA_SIZE  weighting element w(i), i ascending.
- M_IN_ENABLE  in  1  M_IN valid this cycle.
- M_IN  in  DATA_SIZE  memory element M(i,j), column-major.
- R_OUT_ENABLE  out  1  one-cycle pulse: R_OUT and R_INDEX are valid.
- R_OUT  out  DATA_SIZE  read vector element r(j).
- R_INDEX  out  CONTROL_SIZE  j of the current R_OUT.

Behaviour:
- Reset (asynchronous, any state): state IDLE; BUSY, READY and R_OUT_ENABLE = 0; R_OUT and R_INDEX = 0; accumulator, counters and w registers = 0.
- FSM IDLE -> LOAD_W: on START=1 in IDLE. START in any other state is ignored.
- LOAD_W:
  - Each cycle with W_IN_ENABLE=1, store w(i) = W_IN and increment i.
  - After accepting i = N-1, move to LOAD_M with i = 0, j = 0 and accumulator = 0.
  - M_IN_ENABLE is ignored in LOAD_W.
- LOAD_M:
  - Each cycle with M_IN_ENABLE=1, acc += trunc_DATA_SIZE((w(i)*M_IN) >>> FRACTION_SIZE). The product is a full 2*DATA_SIZE signed value with an arithmetic shift; the sum wraps modulo 2^DATA_SIZE.
  - Increment i after each accepted element.
  - W_IN_ENABLE is ignored in LOAD_M.
- Column completion: when i = N-1 is accepted, on the next rising edge:
  - R_OUT = acc + the final term; R_INDEX = j; R_OUT_ENABLE = 1 for one cycle.
  - acc = 0, i = 0, j increments.
  - Latency from the last element of the column to R_OUT_ENABLE is 1 cycle.
- Operation end: if the completed column is j = W-1, READY = 1 in the same cycle as that R_OUT_ENABLE, and the FSM returns to IDLE on that edge.
- The block is always ready: there is no backpressure on inputs. Idle cycles (enable low) in any state are tolerated with no state change.
- R_OUT and R_INDEX hold their last values between pulses.
- BUSY = 1 in LOAD_W and LOAD_M; BUSY = 0 in IDLE, including the READY cycle.
- A new START is accepted on the cycle after READY.
- Degenerate N=1: every accepted M element completes a column, so R_OUT_ENABLE can pulse on consecutive cycles.

Test Plan (N=4, W=3, DATA_SIZE=16, CONTROL_SIZE=8, FRACTION_SIZE=0 unless stated):
1. Select row: w = [0,1,0,0]; column j = [10j, 10j+1, 10j+2, 10j+3], back-to-back -> R_OUT = 1, 11, 21 with R_INDEX 0, 1, 2. Each pulse comes 1 cycle after the 4th element of its column; READY pulses with index 2.
2. Sum with gaps: w = [1,1,1,1], all M = 5; enables toggled pseudo-randomly -> R_OUT = 20, 20, 20; no extra pulses.
3. Signed and wrap: w = [-1,0,0,0] with M(0,0) = 3 -> r(0) = 0xFFFD. Then w = [0x4000 x4] with M = 2 -> each product is 0x8000, the sum wraps -> r = 0x0000.
4. Ignored inputs: START pulsed in LOAD_W and in LOAD_M; M_IN_ENABLE during LOAD_W; W_IN_ENABLE during LOAD_M -> results identical to scenario 1.
5. Reset mid-operation: RST asserted after 2 columns of LOAD_M -> all outputs 0 and BUSY 0 immediately (asynchronous). A fresh run of scenario 1 then gives 1, 11, 21.
6. Fraction: FRACTION_SIZE = 8, w = [0x0180 (1.5), 0, 0, 0], M(0,j) = 0x0200 (2.0) -> r(j) = 0x0300 for each j.
